// File: rtl/ps2_pkg.sv
// PS/2 scan-code constants, key indices, frame FSM encoding and the make-code matcher.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam int FRAME_BITS = 11;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_ENTER = 4;
  localparam int KEY_SPACE = 5;
  localparam int NUM_KEYS  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } frame_state_e;

  // Arrows exist only as extended codes; Enter and Space only as plain codes.
  function automatic logic [NUM_KEYS-1:0] key_match(input logic ext, input logic [7:0] code);
    logic [NUM_KEYS-1:0] hit;
    hit = '0;
    if (ext) begin
      case (code)
        SC_UP:    hit[KEY_UP]    = 1'b1;
        SC_DOWN:  hit[KEY_DOWN]  = 1'b1;
        SC_LEFT:  hit[KEY_LEFT]  = 1'b1;
        SC_RIGHT: hit[KEY_RIGHT] = 1'b1;
        default:  hit = '0;
      endcase
    end else begin
      case (code)
        SC_ENTER: hit[KEY_ENTER] = 1'b1;
        SC_SPACE: hit[KEY_SPACE] = 1'b1;
        default:  hit = '0;
      endcase
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: syncs ps2_clk/ps2_data, registers falling edges (SYNC_STAGES+1 clk after the raw fall),
// and checks 11-bit frames; code_valid/frame_err pulse 1 clk after the stop-bit edge. No backpressure.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 2);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   edge_q, edge_d;
  logic                   bit_q, bit_d;
  frame_state_e           state_q, state_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [8:0]             shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             scan_code_q, scan_code_d;
  logic                   code_valid_q, code_valid_d;
  logic                   frame_err_q, frame_err_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    edge_d      = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    bit_d       = data_sync_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    scan_code_d  = scan_code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (edge_q) cnt_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (edge_q && !bit_q) begin
          state_d  = ST_RECV;
          bitcnt_d = '0;
        end
      end
      ST_RECV: begin
        if (edge_q) begin
          if (bitcnt_q == STOP_IDX) begin
            state_d = ST_CHECK;
            // shift_q holds {parity, data}; odd parity means the XOR over all nine is 1
            if (bit_q && (^shift_q)) begin
              scan_code_d  = shift_q[7:0];
              code_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            shift_d  = {bit_q, shift_q[8:1]};
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end else if (cnt_q == CNT_LAST) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      edge_q       <= 1'b0;
      bit_q        <= 1'b1;
      state_q      <= ST_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      scan_code_q  <= 8'h00;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      edge_q       <= edge_d;
      bit_q        <= bit_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      scan_code_q  <= scan_code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign scan_code  = scan_code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 game-key decoder: E0/F0 prefix tracking, one-cycle key pulses 1 clk after code_valid; no backpressure.
// Define PS2_NOREPEAT_EN to suppress typematic repeats with a per-key held register.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       space,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  logic [NUM_KEYS-1:0] key_q, key_d;
  logic [NUM_KEYS-1:0] hit;
`ifdef PS2_NOREPEAT_EN
  logic [NUM_KEYS-1:0] held_q, held_d;
`endif

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  assign hit = key_match(ext_q, scan_code);

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    key_d = '0;
`ifdef PS2_NOREPEAT_EN
    held_d = held_q;
`endif
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
`ifdef PS2_NOREPEAT_EN
      held_d = '0;
`endif
    end else if (code_valid) begin
      if (scan_code == SC_EXT) begin
        ext_d = 1'b1;
      end else if (scan_code == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
`ifdef PS2_NOREPEAT_EN
        if (!brk_q) begin
          key_d  = hit & ~held_q;
          held_d = held_q | hit;
        end else begin
          held_d = held_q & ~hit;
        end
`else
        if (!brk_q) key_d = hit;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      key_q <= '0;
`ifdef PS2_NOREPEAT_EN
      held_q <= '0;
`endif
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      key_q <= key_d;
`ifdef PS2_NOREPEAT_EN
      held_q <= held_d;
`endif
    end
  end

  assign up    = key_q[KEY_UP];
  assign down  = key_q[KEY_DOWN];
  assign left  = key_q[KEY_LEFT];
  assign right = key_q[KEY_RIGHT];
  assign enter = key_q[KEY_ENTER];
  assign space = key_q[KEY_SPACE];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: frames are driven bit by bit, expected events queued, DUT events popped.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int TO   = 300;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data;
  logic up, down, left, right, enter, space, code_valid, frame_err;
  logic [7:0] scan_code;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up), .down(down), .left(left), .right(right), .enter(enter), .space(space),
    .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_stop_cyc = 0;
  int enter_cnt = 0;
  logic prev_cv = 1'b0;
  logic [31:0] exp_q[$];
  logic [5:0] keys_obs;

  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [5:0] m_held = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) chk(tag, obs, 32'h0);
    else chk(tag, obs, exp_q.pop_front());
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Event encoding: 0x1xx code_valid with byte, 0x2xx key one-hot {space,enter,right,left,down,up}, 0x300 frame_err
  always @(negedge clk) begin
    if (!rst) begin
      keys_obs = {space, enter, right, left, down, up};
      if (code_valid) begin
        chk("cv_latency", 32'(cyc - last_stop_cyc), 32'(SYNC + 2));
        pop_cmp("code", 32'h100 | {24'h0, scan_code});
      end
      if (frame_err) pop_cmp("err", 32'h300);
      if (keys_obs != 6'b0) begin
        chk("key_latency", {31'h0, prev_cv}, 32'h1);
        pop_cmp("key", 32'h200 | {26'h0, keys_obs});
      end
      if (enter) enter_cnt <= enter_cnt + 1;
      prev_cv <= code_valid;
    end
  end

  function automatic logic [5:0] exp_key(input logic ext, input logic [7:0] b);
    case ({ext, b})
      9'h175:  return 6'b000001;
      9'h172:  return 6'b000010;
      9'h16B:  return 6'b000100;
      9'h174:  return 6'b001000;
      9'h05A:  return 6'b010000;
      9'h029:  return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic model_err();
    exp_q.push_back(32'h300);
    m_ext = 1'b0; m_brk = 1'b0; m_held = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [5:0] k;
    exp_q.push_back(32'h100 | {24'h0, b});
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      k = exp_key(m_ext, b);
      if (!m_brk) begin
`ifdef PS2_NOREPEAT_EN
        if (k != 0 && (k & m_held) == 0) exp_q.push_back(32'h200 | {26'h0, k});
        m_held = m_held | k;
`else
        if (k != 0) exp_q.push_back(32'h200 | {26'h0, k});
`endif
      end else begin
        m_held = m_held & ~k;
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b, input bit is_stop);
    @(negedge clk); ps2_data = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) last_stop_cyc = cyc;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_bits(input logic [10:0] bits, input int from, input int upto);
    for (int i = from; i < upto; i++) drive_bit(bits[i], i == 10);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    if (bad_par) model_err();
    else model_byte(b);
    drive_bits(mk_frame(b, bad_par), 0, 11);
    repeat (30) @(negedge clk);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {22'h0, up, down, left, right, enter, space, code_valid, frame_err, 2'b00}, 32'h0);
  endtask

  initial begin
    logic [10:0] f;
    int e0;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset_outs");
    chk("reset_scan", {24'h0, scan_code}, 32'h0);
    chk("reset_state", 32'(dut.u_rx.state_q), 32'(ST_IDLE));
    chk("reset_flags", {30'h0, dut.ext_q, dut.brk_q}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk_outs_zero("post_reset");

    send_frame(8'h29, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("flags_after_break", {30'h0, dut.ext_q, dut.brk_q}, 32'h0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h5A, 1'b0);
    send_frame(8'hAA, 1'b0);

    send_frame(8'h5A, 1'b1);
    send_frame(8'h5A, 1'b0);

    // E0 pending, then a frame that stalls after 4 bits: the timeout must also drop the prefix
    send_frame(8'hE0, 1'b0);
    model_err();
    drive_bits(mk_frame(8'h6B, 1'b0), 0, 5);
    repeat (TO + 40) @(negedge clk);
    chk("timeout_idle", 32'(dut.u_rx.state_q), 32'(ST_IDLE));
    chk("timeout_flags", {30'h0, dut.ext_q, dut.brk_q}, 32'h0);
    send_frame(8'h6B, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h6B, 1'b0);

    e0 = enter_cnt;
    send_frame(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    send_frame(8'h5A, 1'b0);
`ifdef PS2_NOREPEAT_EN
    chk("enter_repeats", 32'(enter_cnt - e0), 32'd2);
`else
    chk("enter_repeats", 32'(enter_cnt - e0), 32'd3);
`endif

    // Reset during frame bit 5 of F0; every remaining bit is 1 so nothing restarts afterwards
    f = mk_frame(8'hF0, 1'b0);
    drive_bits(f, 0, 5);
    @(negedge clk); ps2_data = f[5];
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_outs_zero("mid_reset_outs");
    chk("mid_reset_scan", {24'h0, scan_code}, 32'h0);
    m_ext = 1'b0; m_brk = 1'b0; m_held = '0;
    repeat (6) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outs_zero("mid_reset_release");
    drive_bits(f, 6, 11);
    repeat (30) @(negedge clk);
    send_frame(8'h29, 1'b0);

    repeat (50) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
